morse_decoder: RTL
==================

Name: morse_decoder

Overview:
- Downstream consumer of the lab5 Morse transmitter's serial LED line (LEDR[9]-style output, 1 unit = 0.5 s).
- Measures mark/space run lengths in units, classifies dot/dash, and assembles up to 4 symbols per letter.
- At a letter gap, it matches the symbols against letters A–H and emits a 3-bit letter code (same SW encoding, A=0 … H=7) with a one-cycle valid or error strobe.

Parameters:
- TICK_COUNT, 25000000: CLOCK_50 cycles per Morse unit. Benches use 8.
- HALF_COUNT, TICK_COUNT/2: offset of the first sample after an edge, placing samples mid-unit.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous, active-low reset.
- morse_in  in  1  serial Morse line. Asynchronous to the transmitter's unit phase; 1 = lit.
- letter  out  3  decoded letter code: A=0, B=1, C=2, D=3, E=4, F=5, G=6, H=7.
- letter_valid  out  1  one-cycle pulse; letter is valid in the same cycle.
- letter_err  out  1  one-cycle pulse; the symbol sequence was malformed or unmatched.
- busy  out  1  high while in MARK or SPACE.

Behaviour:
- Reset: CLOCK_50 plus asynchronous, active-low resetn. All outputs are 0 after reset. Synchronizer flops reset to 0; FSM resets to IDLE; symbol register, counts and timer reset to 0.
- Input path:
  - 2-flop synchronizer, then an edge detector on the synchronized value (rise/fall flags).
  - Adds 2 cycles of fixed latency.
- Unit timer:
  - Any edge clears the timer and sets run_units to 0.
  - run_units increments when the timer reaches HALF_COUNT-1, then every TICK_COUNT cycles after that.
  - run_units saturates at 7.
  - Result: a run of N units reads as N, with ±half-unit tolerance.
- FSM states: IDLE, MARK, SPACE.
  - IDLE:
    - rise -> MARK; clear sym_reg, sym_cnt and err_flag.
    - A fall in IDLE is ignored.
  - MARK, on fall:
    - run_units==1 appends dot (0).
    - run_units==3 appends dash (1).
    - Any other value sets err_flag.
    - If sym_cnt is already 4, set err_flag and do not append.
    - Go to SPACE.
    - Symbols are shifted in LSB-first order of arrival; sym_cnt is a 3-bit count.
  - SPACE:
    - rise with run_units==1 -> MARK (intra-letter gap).
    - rise with run_units==0 or 2 -> MARK with err_flag set.
    - run_units reaching 3 while low ends the letter: decode, then go to IDLE.
- Decode, registered, output one cycle after run_units reaches 3:
  - If err_flag is 0 and (sym_cnt, sym_reg) matches an entry: letter <= code and letter_valid pulses.
  - Otherwise letter_err pulses and letter holds its previous value.
- Letter table:
  - A .-, B -..., C -.-., D -.., E ., F ..-., G --., H ....
  - Any other sequence is an error.
- Strobes: letter_valid and letter_err are never high together. letter holds its value between strobes.
- Simultaneous events: an edge in the same cycle as a sample tick is treated as an edge; the timer clears and that sample is lost.
- resetn asserted mid-letter: immediate return to IDLE and the partial letter is discarded. No strobe is emitted.
- A continuous high with run_units saturated at 7 stays in MARK. The following fall flags an error.

Decomposition:
- Package morse_pkg holds:
  - state encoding (IDLE/MARK/SPACE);
  - letter codes A..H;
  - per-letter symbol-length and pattern constants, used by both this block and the transmitter;
  - MAX_SYMBOLS = 4.
- Sub-module morse_unit_timer: timer plus run_units with saturation. Inputs are edge and tick parameters; the output is run_units.

Test Plan (TICK_COUNT=8, HALF_COUNT=4):
- Reset: hold resetn=0 for 5 cycles with morse_in toggling -> all outputs 0; FSM in IDLE; no strobe after release with morse_in=0.
- Letter A: high 8, low 8, high 24, low 40 -> letter=0 with letter_valid for one cycle, about 20+2 cycles after the last fall; busy low afterwards.
- Back-to-back letters: E (high 8, low 24) then H (4 × high 8/low 8, then low 24) -> letter=4 then letter=7, two valid pulses, no err.
- Malformed mark: high 16 (2 units) then low 40 -> letter_err pulse; letter unchanged.
- Too many symbols: five dots (high 8/low 8 ×5, then low 24) -> letter_err. Unmatched sequence "--" -> letter_err.
- Reset mid-letter: after the first dash of C, pulse resetn low -> busy=0 immediately. A subsequent full B decodes to letter=1 with a clean valid pulse.

Source files
------------

// File: rtl/morse_pkg.sv
// ----------------------------------------------------------------------------
// morse_pkg
//
// Shared definitions for the Morse transmitter/decoder pair:
//   - decoder FSM state encoding
//   - 3-bit letter codes A..H (same encoding as the transmitter's SW input)
//   - per-letter symbol count and symbol pattern tables
//   - a lookup helper that maps (symbol count, pattern) to a letter code
//
// Symbol patterns are stored in arrival order starting at bit 0:
// bit i holds the i-th symbol of the letter (0 = dot, 1 = dash). Bits at
// and above the symbol count are always 0.
// ----------------------------------------------------------------------------
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2
    } state_t;

    localparam int MAX_SYMBOLS = 4;
    localparam int NUM_LETTERS = 8;

    // Symbol count register width is 3 bits so it can hold MAX_SYMBOLS.
    localparam logic [2:0] MAX_SYM_CNT = 3'(MAX_SYMBOLS);

    localparam logic DOT  = 1'b0;
    localparam logic DASH = 1'b1;

    localparam logic [2:0] LTR_A = 3'd0;
    localparam logic [2:0] LTR_B = 3'd1;
    localparam logic [2:0] LTR_C = 3'd2;
    localparam logic [2:0] LTR_D = 3'd3;
    localparam logic [2:0] LTR_E = 3'd4;
    localparam logic [2:0] LTR_F = 3'd5;
    localparam logic [2:0] LTR_G = 3'd6;
    localparam logic [2:0] LTR_H = 3'd7;

    localparam logic [2:0] LETTER_CODE [NUM_LETTERS] = '{
        LTR_A, LTR_B, LTR_C, LTR_D, LTR_E, LTR_F, LTR_G, LTR_H
    };

    // A .-   B -...   C -.-.   D -..   E .   F ..-.   G --.   H ....
    localparam logic [2:0] SYM_LEN [NUM_LETTERS] = '{
        3'd2, 3'd4, 3'd4, 3'd3, 3'd1, 3'd4, 3'd3, 3'd4
    };

    localparam logic [3:0] SYM_PAT [NUM_LETTERS] = '{
        4'b0010,    // A: dot, dash
        4'b0001,    // B: dash, dot, dot, dot
        4'b0101,    // C: dash, dot, dash, dot
        4'b0001,    // D: dash, dot, dot
        4'b0000,    // E: dot
        4'b0100,    // F: dot, dot, dash, dot
        4'b0011,    // G: dash, dash, dot
        4'b0000     // H: dot, dot, dot, dot
    };

    typedef struct packed {
        logic       hit;
        logic [2:0] code;
    } lookup_t;

    // Count and pattern together are unique per letter (B and D share a
    // pattern prefix but differ in length), so at most one entry hits.
    function automatic lookup_t lookup_letter(input logic [2:0] cnt,
                                              input logic [3:0] pat);
        lookup_t res;
        res = '0;
        for (int i = 0; i < NUM_LETTERS; i++) begin
            if ((cnt == SYM_LEN[i]) && (pat == SYM_PAT[i])) begin
                res.hit  = 1'b1;
                res.code = LETTER_CODE[i];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/morse_decoder_unit_timer.sv
// ----------------------------------------------------------------------------
// morse_unit_timer
//
// Measures the length of the current mark or space in Morse units.
// An edge restarts the measurement. The first sample lands HALF_COUNT
// cycles after the edge (mid-unit) and later samples follow every
// TICK_COUNT cycles, so a run of N units reads N with half a unit of
// tolerance either way. run_units saturates at 7.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   edge_seen  in   rise or fall of the synchronized line this cycle
//   run_units  out  units elapsed since the last edge (0..7, saturating)
// ----------------------------------------------------------------------------
module morse_unit_timer #(
    parameter int TICK_COUNT = 25000000,
    parameter int HALF_COUNT = TICK_COUNT / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       edge_seen,
    output logic [2:0] run_units
);

    localparam int TW = $clog2(TICK_COUNT + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(HALF_COUNT - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_COUNT - 1);

    logic [TW-1:0] timer;
    logic          first_done;
    logic          tick;

    // Before the first sample the period is half a unit, afterwards a
    // full unit.
    assign tick = first_done ? (timer == TICK_LAST) : (timer == HALF_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer      <= '0;
            first_done <= 1'b0;
            run_units  <= 3'd0;
        end else if (edge_seen) begin
            // An edge wins over a coincident tick: that sample is dropped.
            timer      <= '0;
            first_done <= 1'b0;
            run_units  <= 3'd0;
        end else if (tick) begin
            timer      <= '0;
            first_done <= 1'b1;
            if (run_units != 3'd7) begin
                run_units <= run_units + 3'd1;
            end
        end else begin
            timer <= timer + TW'(1);
        end
    end

endmodule

// File: rtl/morse_decoder.sv
// ----------------------------------------------------------------------------
// morse_decoder
//
// Receives the serial Morse LED line from the lab5 transmitter, measures
// mark/space lengths in units, classifies dots (1 unit) and dashes
// (3 units), collects up to four symbols per letter and, once a letter
// gap (3 units low) is seen, decodes the letter A..H.
//
// Ports:
//   CLOCK_50      in   system clock
//   resetn        in   asynchronous active-low reset
//   morse_in      in   serial Morse line, 1 = lit, asynchronous
//   letter        out  last decoded letter code (A=0 .. H=7), held
//   letter_valid  out  one-cycle pulse, letter is valid in that cycle
//   letter_err    out  one-cycle pulse, malformed or unmatched letter
//   busy          out  high while a letter is being received
//   fsm_state     out  current decoder state (debug visibility)
//
// Strobe semantics: letter_valid and letter_err are single-cycle pulses,
// mutually exclusive, with no back-pressure; the consumer must capture
// letter in the cycle letter_valid is high. letter keeps its value
// between strobes and is unchanged by an error.
// ----------------------------------------------------------------------------
import morse_pkg::*;

module morse_decoder #(
    parameter int TICK_COUNT = 25000000,
    parameter int HALF_COUNT = TICK_COUNT / 2
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       morse_in,
    output logic [2:0] letter,
    output logic       letter_valid,
    output logic       letter_err,
    output logic       busy,
    output state_t     fsm_state
);

    // ------------------------------------------------------------------
    // Input path: two-flop synchronizer plus a delayed copy for edges.
    // ------------------------------------------------------------------
    logic sync_a;
    logic sync_b;
    logic line_prev;
    logic rise;
    logic fall;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync_a    <= 1'b0;
            sync_b    <= 1'b0;
            line_prev <= 1'b0;
        end else begin
            sync_a    <= morse_in;
            sync_b    <= sync_a;
            line_prev <= sync_b;
        end
    end

    assign rise = sync_b & ~line_prev;
    assign fall = ~sync_b & line_prev;

    // ------------------------------------------------------------------
    // Run-length measurement
    // ------------------------------------------------------------------
    logic [2:0] run_units;

    morse_unit_timer #(
        .TICK_COUNT (TICK_COUNT),
        .HALF_COUNT (HALF_COUNT)
    ) u_timer (
        .clk       (CLOCK_50),
        .rst_n     (resetn),
        .edge_seen (rise | fall),
        .run_units (run_units)
    );

    // ------------------------------------------------------------------
    // Letter assembly FSM
    // ------------------------------------------------------------------
    state_t     state;
    logic [3:0] sym_reg;
    logic [2:0] sym_cnt;
    logic       err_flag;
    lookup_t    lookup;

    assign lookup    = lookup_letter(sym_cnt, sym_reg);
    assign fsm_state = state;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            sym_reg      <= 4'd0;
            sym_cnt      <= 3'd0;
            err_flag     <= 1'b0;
            letter       <= 3'd0;
            letter_valid <= 1'b0;
            letter_err   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            letter_valid <= 1'b0;
            letter_err   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // A stray fall here (e.g. line high out of reset) is
                    // simply ignored.
                    if (rise) begin
                        state    <= ST_MARK;
                        busy     <= 1'b1;
                        sym_reg  <= 4'd0;
                        sym_cnt  <= 3'd0;
                        err_flag <= 1'b0;
                    end
                end

                ST_MARK: begin
                    // A mark that never ends just sits here with
                    // run_units saturated; its eventual fall is an error.
                    if (fall) begin
                        state <= ST_SPACE;
                        if (sym_cnt == MAX_SYM_CNT) begin
                            err_flag <= 1'b1;
                        end else if (run_units == 3'd1) begin
                            sym_reg[sym_cnt[1:0]] <= DOT;
                            sym_cnt               <= sym_cnt + 3'd1;
                        end else if (run_units == 3'd3) begin
                            sym_reg[sym_cnt[1:0]] <= DASH;
                            sym_cnt               <= sym_cnt + 3'd1;
                        end else begin
                            err_flag <= 1'b1;
                        end
                    end
                end

                ST_SPACE: begin
                    if (run_units >= 3'd3) begin
                        // Letter gap: decode what was collected.
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        if (!err_flag && lookup.hit) begin
                            letter       <= lookup.code;
                            letter_valid <= 1'b1;
                        end else begin
                            letter_err   <= 1'b1;
                        end
                    end else if (rise) begin
                        // Only a one-unit gap separates symbols; 0 or 2
                        // units means the timing is off.
                        state <= ST_MARK;
                        if (run_units != 3'd1) begin
                            err_flag <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
